// File: rtl/lenet_pkg.sv
// Shared LeNet-5 datapath constants: accumulator/activation widths, map sizes
// and the default requantization shift.
package lenet_pkg;

  localparam int ACC_WIDTH     = 32;
  localparam int ACT_WIDTH     = 8;

  localparam int C3_MAP_W      = 10;
  localparam int C3_MAP_H      = 10;
  localparam int S4_MAP_W      = 5;
  localparam int S4_MAP_H      = 5;

  localparam int REQUANT_SHIFT = 8;

  typedef logic [ACT_WIDTH-1:0] act_t;

endpackage

// File: rtl/relu_requant.sv
// Combinational ReLU + arithmetic right shift + saturation to a non-negative
// narrow activation. Shared with the fully connected layers.
module relu_requant
  import lenet_pkg::*;
#(
  parameter int IN_WIDTH  = ACC_WIDTH,
  parameter int OUT_WIDTH = ACT_WIDTH,
  parameter int SHIFT     = REQUANT_SHIFT
) (
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic        [OUT_WIDTH-1:0] q
);

  localparam logic [IN_WIDTH-1:0] QMAX = IN_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);

  logic [IN_WIDTH-1:0] relu;
  logic [IN_WIDTH-1:0] shifted;

  // NOTE: combinational blocks use blocking assignments and assign every
  // output on every path, so no latch can be inferred.
  always_comb begin
    relu    = in_data[IN_WIDTH-1] ? '0 : in_data;
    // relu is non-negative, so a logical shift equals the arithmetic one.
    shifted = relu >> SHIFT;
    q       = (shifted > QMAX) ? QMAX[OUT_WIDTH-1:0] : shifted[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/relu_maxpool22.sv
// Streaming ReLU/requant followed by 2x2 stride-2 max pooling over one
// MAP_W x MAP_H raster-order feature map (LeNet-5 C3 -> S4).
module relu_maxpool22
  import lenet_pkg::*;
#(
  parameter int IN_WIDTH  = ACC_WIDTH,
  parameter int OUT_WIDTH = ACT_WIDTH,
  parameter int MAP_W     = C3_MAP_W,
  parameter int MAP_H     = C3_MAP_H,
  parameter int SHIFT     = REQUANT_SHIFT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  output logic        [OUT_WIDTH-1:0] out_data,
  output logic                        frame_done
);

  localparam int HALF_W = MAP_W / 2;
  localparam int COL_W  = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int ROW_W  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  generate
    if ((MAP_W % 2) != 0 || (MAP_H % 2) != 0 || MAP_W < 2 || MAP_H < 2) begin : g_bad_dims
      $fatal(1, "relu_maxpool22: MAP_W and MAP_H must be even and >= 2");
    end
  endgenerate

  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [OUT_WIDTH-1:0] hold;
  logic [OUT_WIDTH-1:0] linebuf [HALF_W];
  logic [OUT_WIDTH-1:0] q;
  logic [OUT_WIDTH-1:0] hmax;
  logic [OUT_WIDTH-1:0] lb_rd;
  logic [IDX_W-1:0]     lb_idx;
  logic                 accept;
  logic                 col_last;
  logic                 row_last;

  relu_requant #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_requant (
    .in_data (in_data),
    .q       (q)
  );

  // clear wins over in_valid: the sample in a clearing cycle is dropped.
  assign accept   = in_valid && !clear;
  assign col_last = (col == COL_W'(MAP_W - 1));
  assign row_last = (row == ROW_W'(MAP_H - 1));
  assign lb_idx   = IDX_W'(col >> 1);
  assign lb_rd    = linebuf[lb_idx];
  assign hmax     = (q > hold) ? q : hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (clear) begin
      hold <= '0;
    end else if (accept && !col[0]) begin
      hold <= q;
    end
  end

  // NOTE: the line buffer has no reset; each entry is written in an even row
  // before the following odd row reads it, so its power-up value never leaks.
  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0]) begin
      linebuf[lb_idx] <= hmax;
    end
  end

  // Window completes on the odd-row/odd-col pixel; result registered once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else if (accept && col[0] && row[0]) begin
      out_valid  <= 1'b1;
      out_data   <= (lb_rd > hmax) ? lb_rd : hmax;
      frame_done <= col_last && row_last;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule
